// File: rtl/flippy_pkg.sv
// Shared FlippyBit definitions: lane count, scheduler state encoding, LFSR taps
// and the speed-level width.
package flippy_pkg;

  localparam int NUM_LANES = 3;
  localparam int LEVEL_W   = 4;

  // Fibonacci taps 8,6,5,4 (bits 7,5,4,3): maximal-length 8-bit sequence
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FROZEN = 2'b10
  } sched_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/flippy_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when step_en is high; reloads seed on reset.
// The seed must be nonzero or the register locks at zero.
module flippy_lfsr8
  import flippy_pkg::*;
(
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       step_en,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (step_en) value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clock) begin
    if (reset_signal) value_q <= seed;
    else              value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/lane_spawn_scheduler.sv
// Lane spawn scheduler: fall-step tick, round-robin target spawning and score-driven speed.
// Define SPEEDUP_EN to shorten the step period with level; otherwise it stays at BASE_PERIOD.
module lane_spawn_scheduler
  import flippy_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned MIN_PERIOD  = 12_500_000,
  parameter int unsigned PERIOD_STEP = 2_500_000,
  parameter int unsigned SPAWN_STEPS = 4,
  parameter int unsigned LEVEL_SHIFT = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset_signal,
  input  logic                 enable,
  input  logic [7:0]           score,
  input  logic [NUM_LANES-1:0] correct,
  input  logic [NUM_LANES-1:0] game_over,
  output logic                 step_tick,
  output logic [NUM_LANES-1:0] spawn,
  output logic [7:0]           spawn_value,
  output logic [NUM_LANES-1:0] occupancy,
  output logic [LEVEL_W-1:0]   level,
  output logic                 frozen
);

`ifdef SPEEDUP_EN
  localparam bit SPEEDUP_ON = 1'b1;
`else
  localparam bit SPEEDUP_ON = 1'b0;
`endif

  localparam logic [7:0] LEVEL_MAX = 8'((1 << LEVEL_W) - 1);

  sched_state_e         state_q, state_d;
  logic [31:0]          step_cnt_q, step_cnt_d;
  logic [15:0]          spawn_cnt_q, spawn_cnt_d;
  logic                 pending_q, pending_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0] occupancy_q, occupancy_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 step_tick_q, step_tick_d;
  logic [NUM_LANES-1:0] spawn_q, spawn_d;
  logic [7:0]           spawn_value_q, spawn_value_d;
  logic                 frozen_q, frozen_d;

  logic [7:0]           lvl_raw;
  logic [LEVEL_W-1:0]   level_calc;
  logic [31:0]          period_dec, period_scaled, period;
  logic [2:0]           cand;
  logic                 found;
  logic [1:0]           pick;
  logic                 tick, attempt, fire, lfsr_step;
  logic [7:0]           lfsr_value;

  flippy_lfsr8 u_lfsr (
    .clock        (clock),
    .reset_signal (reset_signal),
    .step_en      (lfsr_step),
    .seed         (LFSR_SEED),
    .value        (lfsr_value)
  );

  // Period follows the registered level; clamp before subtracting so it never underflows.
  always_comb begin
    lvl_raw       = score >> LEVEL_SHIFT;
    level_calc    = (lvl_raw > LEVEL_MAX) ? LEVEL_MAX[LEVEL_W-1:0] : lvl_raw[LEVEL_W-1:0];
    period_dec    = 32'(level_q) * PERIOD_STEP;
    period_scaled = MIN_PERIOD;
    if (period_dec < BASE_PERIOD && (BASE_PERIOD - period_dec) > MIN_PERIOD)
      period_scaled = BASE_PERIOD - period_dec;
    period        = SPEEDUP_ON ? period_scaled : BASE_PERIOD;
  end

  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 3'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NUM_LANES)) cand = cand - 3'(NUM_LANES);
      if (!found && !occupancy_q[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    spawn_cnt_d   = spawn_cnt_q;
    pending_d     = pending_q;
    rr_ptr_d      = rr_ptr_q;
    occupancy_d   = occupancy_q;
    level_d       = (state_q == FROZEN) ? level_q : level_calc;
    step_tick_d   = 1'b0;
    spawn_d       = '0;
    spawn_value_d = spawn_value_q;
    tick          = 1'b0;
    attempt       = 1'b0;
    fire          = 1'b0;
    lfsr_step     = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      step_cnt_d  = '0;
      spawn_cnt_d = '0;
      pending_d   = 1'b0;
      rr_ptr_d    = 2'd0;
      occupancy_d = '0;
    end else begin
      unique case (state_q)
        IDLE:   state_d = RUN;
        RUN: begin
          // A game_over freezes everything, including any release in the same cycle
          if (|game_over) begin
            state_d = FROZEN;
          end else begin
            tick        = (step_cnt_q >= period - 32'd1);
            step_cnt_d  = tick ? 32'd0 : step_cnt_q + 32'd1;
            step_tick_d = tick;
            if (tick) begin
              if (spawn_cnt_q >= 16'(SPAWN_STEPS - 1)) begin
                spawn_cnt_d = '0;
                attempt     = 1'b1;
              end else begin
                spawn_cnt_d = spawn_cnt_q + 16'd1;
              end
            end
            fire = pending_q && found;
            if (fire) begin
              spawn_d[pick] = 1'b1;
              spawn_value_d = lfsr_value;
              lfsr_step     = 1'b1;
              rr_ptr_d      = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            end
            pending_d   = fire ? 1'b0 : (pending_q | attempt);
            occupancy_d = (occupancy_q & ~correct) | spawn_d;
          end
        end
        FROZEN: state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
    frozen_d = (state_d == FROZEN);
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q       <= IDLE;
      step_cnt_q    <= '0;
      spawn_cnt_q   <= '0;
      pending_q     <= 1'b0;
      rr_ptr_q      <= 2'd0;
      occupancy_q   <= '0;
      level_q       <= '0;
      step_tick_q   <= 1'b0;
      spawn_q       <= '0;
      spawn_value_q <= LFSR_SEED;
      frozen_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      spawn_cnt_q   <= spawn_cnt_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      occupancy_q   <= occupancy_d;
      level_q       <= level_d;
      step_tick_q   <= step_tick_d;
      spawn_q       <= spawn_d;
      spawn_value_q <= spawn_value_d;
      frozen_q      <= frozen_d;
    end
  end

  assign step_tick   = step_tick_q;
  assign spawn       = spawn_q;
  assign spawn_value = spawn_value_q;
  assign occupancy   = occupancy_q;
  assign level       = level_q;
  assign frozen      = frozen_q;

endmodule
